// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control signal bundle between the pipeline datapath and pipe_hazard_ctrl.
// The datapath side uses the master modport and the controller uses the slave modport.
interface pipe_hazard_ctrl_if;
    logic        ex_branch_taken;
    logic        ex_mc_start;
    logic        imem_ready;
    logic        idex_mem_read;
    logic [4:0]  idex_rd;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        ex_stall;
    logic        imem_err;
    logic [1:0]  state_o;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushes;

    modport slave (
        input  ex_branch_taken, ex_mc_start, imem_ready, idex_mem_read,
        input  idex_rd, ifid_rs1, ifid_rs2,
        output pc_write, ifid_write, ifid_flush, idex_flush, ex_stall,
        output imem_err, state_o, perf_stall_cycles, perf_flushes
    );

    modport master (
        output ex_branch_taken, ex_mc_start, imem_ready, idex_mem_read,
        output idex_rd, ifid_rs1, ifid_rs2,
        input  pc_write, ifid_write, ifid_flush, idex_flush, ex_stall,
        input  imem_err, state_o, perf_stall_cycles, perf_flushes
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: branch redirect, multi-cycle EX, fetch wait, load-use.
// Define PIPE_HAZARD_PERF_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int MC_LATENCY   = 4,
    parameter int IMEM_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_ctrl_if.slave   hz
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MC_BUSY   = 2'd1,
        IMEM_WAIT = 2'd2,
        ERROR     = 2'd3
    } state_t;

    localparam bit               MC_MULTI = (MC_LATENCY > 1);
    localparam logic [CNT_W-1:0] MC_LOAD  = CNT_W'(MC_MULTI ? MC_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(IMEM_TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] mc_cnt_reg, mc_cnt_next;
    logic [CNT_W-1:0] to_cnt_reg, to_cnt_next;
    logic             pc_write_c, ifid_write_c, ifid_flush_c, idex_flush_c, ex_stall_c;
    logic             load_use;

    assign load_use = hz.idex_mem_read && (hz.idex_rd != 5'd0) &&
                      ((hz.idex_rd == hz.ifid_rs1) || (hz.idex_rd == hz.ifid_rs2));

    always_comb begin
        state_next   = state_reg;
        mc_cnt_next  = mc_cnt_reg;
        to_cnt_next  = to_cnt_reg;
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        ex_stall_c   = 1'b0;
        case (state_reg)
            RUN: begin
                if (hz.ex_branch_taken) begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                end else if (hz.ex_mc_start && MC_MULTI) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    ex_stall_c   = 1'b1;
                    mc_cnt_next  = MC_LOAD;
                    state_next   = MC_BUSY;
                end else if (!hz.imem_ready) begin
                    pc_write_c   = 1'b0;
                    ifid_flush_c = 1'b1;
                    to_cnt_next  = '0;
                    state_next   = IMEM_WAIT;
                end else if (load_use) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    idex_flush_c = 1'b1;
                end
            end
            MC_BUSY: begin
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                ex_stall_c   = 1'b1;
                if (mc_cnt_reg == '0) begin
                    state_next = RUN;
                end else begin
                    mc_cnt_next = mc_cnt_reg - CNT_W'(1);
                end
            end
            IMEM_WAIT: begin
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                ifid_flush_c = 1'b1;
                // A redirect restarts the fetch, so the timeout window restarts with it.
                if (hz.ex_branch_taken) begin
                    pc_write_c   = 1'b1;
                    idex_flush_c = 1'b1;
                    to_cnt_next  = '0;
                end else if (hz.imem_ready) begin
                    pc_write_c   = 1'b1;
                    ifid_write_c = 1'b1;
                    ifid_flush_c = 1'b0;
                    state_next   = RUN;
                end else begin
                    to_cnt_next = to_cnt_reg + CNT_W'(1);
                    if (to_cnt_next == TO_LAST) begin
                        state_next = ERROR;
                    end
                end
            end
            ERROR: begin
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
            end
            default: state_next = RUN;
        endcase
        if (!reset) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            ex_stall_c   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= RUN;
            mc_cnt_reg <= '0;
            to_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            mc_cnt_reg <= mc_cnt_next;
            to_cnt_reg <= to_cnt_next;
        end
    end

    assign hz.pc_write   = pc_write_c;
    assign hz.ifid_write = ifid_write_c;
    assign hz.ifid_flush = ifid_flush_c;
    assign hz.idex_flush = idex_flush_c;
    assign hz.ex_stall   = ex_stall_c;
    assign hz.imem_err   = (state_reg == ERROR);
    assign hz.state_o    = state_reg;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_flush_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (!pc_write_c) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
            if (ifid_flush_c || idex_flush_c) begin
                perf_flush_reg <= perf_flush_reg + 32'd1;
            end
        end
    end

    assign hz.perf_stall_cycles = perf_stall_reg;
    assign hz.perf_flushes      = perf_flush_reg;
`else
    assign hz.perf_stall_cycles = '0;
    assign hz.perf_flushes      = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a cycle-count reference model.
module tb_pipe_hazard_ctrl;
    localparam int MC_LAT = 4;
    localparam int TMO    = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(.MC_LATENCY(MC_LAT), .IMEM_TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (rst),
        .hz    (hz)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: remaining busy cycles, fetch-wait length so far, sticky error.
    int          m_mc_left = 0;
    bit          m_wait    = 1'b0;
    int          m_wait_n  = 0;
    bit          m_err     = 1'b0;
    logic [31:0] m_pstall  = '0;
    logic [31:0] m_pflush  = '0;
    int          n_mc_left, n_wait_n;
    bit          n_wait, n_err;
    bit          e_pc, e_ifw, e_iff, e_idf, e_st;
    logic [1:0]  e_state;

    function automatic void model_eval();
        bit lu;
        lu = hz.idex_mem_read && (hz.idex_rd != 5'd0) &&
             (hz.idex_rd == hz.ifid_rs1 || hz.idex_rd == hz.ifid_rs2);
        e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_st = 0;
        n_mc_left = m_mc_left; n_wait = m_wait; n_wait_n = m_wait_n; n_err = m_err;
        e_state = m_err ? 2'd3 : (m_mc_left > 0) ? 2'd1 : m_wait ? 2'd2 : 2'd0;
        if (!rst) begin
            e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
            n_mc_left = 0; n_wait = 0; n_wait_n = 0; n_err = 0;
        end else if (m_err) begin
            e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
        end else if (m_mc_left > 0) begin
            e_pc = 0; e_ifw = 0; e_st = 1;
            n_mc_left = m_mc_left - 1;
        end else if (m_wait) begin
            if (hz.ex_branch_taken) begin
                e_ifw = 0; e_iff = 1; e_idf = 1;
                n_wait_n = 1;
            end else if (hz.imem_ready) begin
                n_wait = 0;
            end else begin
                e_pc = 0; e_ifw = 0; e_iff = 1;
                n_wait_n = m_wait_n + 1;
                if (n_wait_n >= TMO) begin
                    n_err = 1; n_wait = 0;
                end
            end
        end else begin
            if (hz.ex_branch_taken) begin
                e_iff = 1; e_idf = 1;
            end else if (hz.ex_mc_start && MC_LAT > 1) begin
                e_pc = 0; e_ifw = 0; e_st = 1;
                n_mc_left = MC_LAT - 1;
            end else if (!hz.imem_ready) begin
                e_pc = 0; e_iff = 1;
                n_wait = 1; n_wait_n = 1;
            end else if (lu) begin
                e_pc = 0; e_ifw = 0; e_idf = 1;
            end
        end
    endfunction

    always @(posedge clk) begin
        model_eval();
        if (!rst) begin
            m_pstall = '0;
            m_pflush = '0;
        end else begin
            if (!e_pc) m_pstall = m_pstall + 32'd1;
            if (e_iff || e_idf) m_pflush = m_pflush + 32'd1;
        end
        m_mc_left = n_mc_left; m_wait = n_wait; m_wait_n = n_wait_n; m_err = n_err;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] exp_ps, exp_pf;
            model_eval();
`ifdef PIPE_HAZARD_PERF_EN
            exp_ps = m_pstall;
            exp_pf = m_pflush;
`else
            exp_ps = '0;
            exp_pf = '0;
`endif
            chk("m_pc_write",   32'(hz.pc_write),   32'(e_pc));
            chk("m_ifid_write", 32'(hz.ifid_write), 32'(e_ifw));
            chk("m_ifid_flush", 32'(hz.ifid_flush), 32'(e_iff));
            chk("m_idex_flush", 32'(hz.idex_flush), 32'(e_idf));
            chk("m_ex_stall",   32'(hz.ex_stall),   32'(e_st));
            chk("m_imem_err",   32'(hz.imem_err),   32'(m_err));
            chk("m_state",      32'(hz.state_o),    32'(e_state));
            chk("m_perf_stall", hz.perf_stall_cycles, exp_ps);
            chk("m_perf_flush", hz.perf_flushes,      exp_pf);
        end
    end

    task automatic drive(input bit br, input bit mc, input bit rdy, input bit mr,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        @(posedge clk);
        #1;
        hz.ex_branch_taken = br;
        hz.ex_mc_start     = mc;
        hz.imem_ready      = rdy;
        hz.idex_mem_read   = mr;
        hz.idex_rd         = rd;
        hz.ifid_rs1        = rs1;
        hz.ifid_rs2        = rs2;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        hz.ex_branch_taken = 0; hz.ex_mc_start = 0; hz.imem_ready = 1;
        hz.idex_mem_read = 0; hz.idex_rd = 0; hz.ifid_rs1 = 0; hz.ifid_rs2 = 0;
        rst = 0;
        @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        chk("rst_pc_write",   32'(hz.pc_write),   32'd0);
        chk("rst_ifid_flush", 32'(hz.ifid_flush), 32'd1);
        chk("rst_idex_flush", 32'(hz.idex_flush), 32'd1);
        chk("rst_ex_stall",   32'(hz.ex_stall),   32'd0);
        chk("rst_state",      32'(hz.state_o),    32'd0);
        @(posedge clk);
        #1 rst = 1;
        idle();
        chk("idle_pc_write", 32'(hz.pc_write), 32'd1);

        // Load-use: one stall cycle, then defaults; rd==x0 never stalls.
        drive(0, 0, 1, 1, 5'd5, 5'd0, 5'd5);
        chk("lu_pc_write",   32'(hz.pc_write),   32'd0);
        chk("lu_ifid_write", 32'(hz.ifid_write), 32'd0);
        chk("lu_idex_flush", 32'(hz.idex_flush), 32'd1);
        idle();
        chk("lu_after_pc",   32'(hz.pc_write),   32'd1);
        drive(0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
        chk("lu_x0_pc",      32'(hz.pc_write),   32'd1);

        // Branch outranks multi-cycle start and load-use.
        drive(1, 1, 1, 1, 5'd7, 5'd7, 5'd0);
        chk("br_ifid_flush", 32'(hz.ifid_flush), 32'd1);
        chk("br_idex_flush", 32'(hz.idex_flush), 32'd1);
        chk("br_pc_write",   32'(hz.pc_write),   32'd1);
        chk("br_ex_stall",   32'(hz.ex_stall),   32'd0);
        idle();
        chk("br_state",      32'(hz.state_o),    32'd0);

        // Multi-cycle op: 4 stall cycles, branch in cycle 2 ignored, RUN on cycle 5.
        drive(0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
        chk("mc_c1_stall", 32'(hz.ex_stall), 32'd1);
        drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        chk("mc_c2_stall", 32'(hz.ex_stall),   32'd1);
        chk("mc_c2_state", 32'(hz.state_o),    32'd1);
        chk("mc_c2_flush", 32'(hz.idex_flush), 32'd0);
        idle();
        chk("mc_c3_stall", 32'(hz.ex_stall), 32'd1);
        idle();
        chk("mc_c4_stall", 32'(hz.ex_stall), 32'd1);
        idle();
        chk("mc_c5_stall", 32'(hz.ex_stall), 32'd0);
        chk("mc_c5_state", 32'(hz.state_o),  32'd0);

        // Fetch wait for 3 cycles, then ready.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
            chk("fw_ifid_flush", 32'(hz.ifid_flush), 32'd1);
            chk("fw_pc_write",   32'(hz.pc_write),   32'd0);
        end
        idle();
        chk("fw_rdy_ifid_write", 32'(hz.ifid_write), 32'd1);
        chk("fw_rdy_pc_write",   32'(hz.pc_write),   32'd1);
        idle();
        chk("fw_rdy_state",      32'(hz.state_o),    32'd0);

        // Timeout: 16 wait cycles, ERROR from the 17th, sticky until reset.
        for (int i = 0; i < TMO; i++) drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        chk("to_c16_state", 32'(hz.state_o),  32'd2);
        chk("to_c16_err",   32'(hz.imem_err), 32'd0);
        drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        chk("to_err_state", 32'(hz.state_o),  32'd3);
        chk("to_err",       32'(hz.imem_err), 32'd1);
        idle();
        idle();
        chk("to_sticky",    32'(hz.imem_err), 32'd1);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("to_rst_state", 32'(hz.state_o),  32'd0);
        chk("to_rst_err",   32'(hz.imem_err), 32'd0);

        // Reset during MC_BUSY cycle 2 aborts the op.
        drive(0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1 rst = 0;
        hz.ex_mc_start = 0;
        @(negedge clk);
        chk("rmc_state_busy", 32'(hz.state_o),  32'd1);
        chk("rmc_ex_stall",   32'(hz.ex_stall), 32'd0);
        @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("rmc_state", 32'(hz.state_o),  32'd0);
        chk("rmc_stall", 32'(hz.ex_stall), 32'd0);
`ifdef PIPE_HAZARD_PERF_EN
        chk("rmc_perf_stall", hz.perf_stall_cycles, 32'd0);
        chk("rmc_perf_flush", hz.perf_flushes,      32'd0);
`endif

        // Random traffic: mostly-ready fetch, then a fetch-starved phase that reaches ERROR.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 3000; i++) begin
                @(posedge clk);
                #1;
                rst                = ($urandom_range(0, 99) < (ph == 0 ? 1 : 3)) ? 1'b0 : 1'b1;
                hz.ex_branch_taken = ($urandom_range(0, 99) < 10);
                hz.ex_mc_start     = ($urandom_range(0, 99) < 6);
                hz.imem_ready      = ($urandom_range(0, 99) < (ph == 0 ? 88 : 4));
                hz.idex_mem_read   = ($urandom_range(0, 99) < 35);
                hz.idex_rd         = 5'($urandom_range(0, 3));
                hz.ifid_rs1        = 5'($urandom_range(0, 3));
                hz.ifid_rs2        = 5'($urandom_range(0, 3));
            end
        end
        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
